// File: rtl/iob_eth_tx_frame_buf.sv
// CPU-side Ethernet TX frame buffer: native-bus word FIFO plus a byte serialiser
// that streams a frame of programmable length into the MAC transmit path.
module iob_eth_tx_frame_buf #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int FIFO_AW = 4,
  parameter int LEN_W   = 11
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  output logic                  tx_last_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_FIFO   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_START  = ADDR_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [FIFO_AW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]         shift_q, shift_d;
  logic [1:0]          idx_q, idx_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                tx_valid_q, tx_valid_d;
  logic                tx_last_q, tx_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [FIFO_AW:0]    level_s;
  logic                full_s, empty_s;
  logic                wr_s, rd_s, push_s, start_wr_s, start_ok_s;
  logic [LEN_W-1:0]    len_s;
  logic [LEN_W:0]      need_s;
  logic [DATA_W-1:0]   status_s;

  assign level_s    = wptr_q - rptr_q;
  assign full_s     = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign empty_s    = (wptr_q == rptr_q);
  assign wr_s       = valid && (wstrb != '0);
  assign rd_s       = valid && (wstrb == '0);
  assign len_s      = wdata[LEN_W-1:0];
  // Words needed to cover len bytes, rounded up.
  assign need_s     = ({1'b0, len_s} + (LEN_W+1)'(3)) >> 2;
  assign start_wr_s = wr_s && (address == A_START);
  assign start_ok_s = (state_q == IDLE) && (len_s != '0) &&
                      (need_s <= {{(LEN_W-FIFO_AW){1'b0}}, level_s});
  assign push_s     = wr_s && (address == A_FIFO) && !full_s;

  // Bus response, status image, error flag and FIFO pointers.
  always_comb begin
    status_s              = '0;
    status_s[FIFO_AW:0]   = level_s;
    status_s[16]          = busy_q;
    status_s[17]          = full_s;
    status_s[18]          = empty_s;
    status_s[24]          = err_q;

    ready_d = valid;
    if (rd_s && (address == A_STATUS)) begin
      rdata_d = status_s;
    end else begin
      rdata_d = '0;
    end

    if (wr_s && (address == A_STATUS) && wdata[24]) begin
      err_d = 1'b0;
    end else if (wr_s && (address == A_FIFO) && full_s) begin
      err_d = 1'b1;
    end else if (start_wr_s && !start_ok_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    wptr_d = push_s ? (wptr_q + (FIFO_AW+1)'(1)) : wptr_q;
    rptr_d = (state_q == LOAD) ? (rptr_q + (FIFO_AW+1)'(1)) : rptr_q;
  end

  // Serialiser FSM; the word in LOAD is popped even when only part of it is sent.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_wr_s && start_ok_s) begin
          state_d = LOAD;
          cnt_d   = len_s;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        shift_d = mem_q[rptr_q[FIFO_AW-1:0]];
        idx_d   = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready_i) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end else if (idx_q == 2'd3) begin
            state_d = LOAD;
          end else begin
            shift_d = shift_q >> 6'd8;
            idx_d   = idx_q + 2'd1;
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tx_valid_d = (state_d == SEND);
    tx_last_d  = (state_d == SEND) && (cnt_d == LEN_W'(1));
    busy_d     = (state_d == LOAD) || (state_d == SEND);
    done_d     = (state_d == DONE);
  end

  // FIFO storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wptr_q[FIFO_AW-1:0]] <= wdata;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      shift_q    <= '0;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rdata      = rdata_q;
  assign ready      = ready_q;
  assign tx_data_o  = shift_q[7:0];
  assign tx_valid_o = tx_valid_q;
  assign tx_last_o  = tx_last_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_iob_eth_tx_frame_buf.sv
// Scoreboard bench for iob_eth_tx_frame_buf: bus reads and TX bytes are queued
// as expectations at issue time and checked by a free-running monitor.
module tb_iob_eth_tx_frame_buf;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        valid;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, tx_last_o, tx_ready_i, busy_o, done_o;

  always #5 clk_i = ~clk_i;

  iob_eth_tx_frame_buf dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_last_o(tx_last_o),
    .tx_ready_i(tx_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] bus_q[$];
  logic [8:0]  tx_q[$];
  int          done_cnt = 0;
  int          tx_cnt = 0;
  int          tx_mode = 0;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  always @(posedge clk_i) prev_valid <= valid;

  // MAC-side ready: constant 1 or toggling every cycle.
  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (tx_mode == 1) tx_ready_i = ~tx_ready_i;
      else              tx_ready_i = 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a bus response or TX byte.
  initial begin
    logic       stall_prev;
    logic [8:0] stall_data;
    logic       last_prev;
    stall_prev = 1'b0;
    stall_data = 9'd0;
    last_prev  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (ready || prev_valid) check("ready_pulse", {31'd0, ready}, {31'd0, prev_valid});
      if (ready) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rdata_unexpected: got 0x%08h expected no response", rdata);
        end else begin
          check("rdata", rdata, bus_q.pop_front());
        end
      end
      if (stall_prev)
        check("tx_hold", {22'd0, tx_valid_o, tx_last_o, tx_data_o}, {22'd0, 1'b1, stall_data});
      if (tx_last_o && !tx_valid_o) begin
        total++; bad++;
        $display("FAIL last_without_valid: got last=1 valid=0 expected last=0");
      end
      if (done_o || last_prev) check("done_pulse", {31'd0, done_o}, {31'd0, last_prev});
      if (done_o) done_cnt++;
      if (tx_valid_o && tx_ready_i) begin
        tx_cnt++;
        if (tx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got byte 0x%02h last=%0b expected none", tx_data_o, tx_last_o);
        end else begin
          check("tx_byte", {23'd0, tx_last_o, tx_data_o}, {23'd0, tx_q.pop_front()});
        end
        last_prev = tx_last_o;
      end else begin
        last_prev = 1'b0;
      end
      stall_prev = tx_valid_o && !tx_ready_i;
      stall_data = {tx_last_o, tx_data_o};
    end
  end

  task automatic bus_op(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp);
    @(posedge clk_i);
    #1;
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    bus_q.push_back(exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    bus_op(a, d, 4'hF, 32'h0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp);
    bus_op(a, 32'h0, 4'h0, exp);
  endtask

  task automatic bus_idle();
    @(posedge clk_i);
    #1;
    valid = 1'b0; address = 16'h0; wdata = 32'h0; wstrb = 4'h0;
  endtask

  task automatic exp_byte(input logic [7:0] b, input logic last);
    tx_q.push_back({last, b});
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 500) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    check(name, done_cnt, target);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    arst_n_i = 1'b0; valid = 1'b0; address = 16'h0; wdata = 32'h0; wstrb = 4'h0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_ctrl", {26'd0, ready, tx_valid_o, tx_last_o, busy_o, done_o, 1'b0},
          32'h0);
    check("reset_txdata", {24'd0, tx_data_o}, 32'h0);
    arst_n_i = 1'b1;
    rd(16'd0, 32'h0004_0000);
    bus_idle();

    // Aligned 8-byte frame.
    wr(16'd1, 32'h4433_2211);
    wr(16'd1, 32'h8877_6655);
    rd(16'd0, 32'h0000_0002);
    bus_idle();
    exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b0); exp_byte(8'h44, 1'b0);
    exp_byte(8'h55, 1'b0); exp_byte(8'h66, 1'b0); exp_byte(8'h77, 1'b0); exp_byte(8'h88, 1'b1);
    wr(16'd2, 32'd8);
    bus_idle();
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    check("no_valid_in_load", {31'd0, tx_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    check("first_byte", {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, 8'h11});
    wait_done(1, "aligned_done");
    rd(16'd0, 32'h0004_0000);
    bus_idle();

    // Partial final word with backpressure.
    wr(16'd1, 32'hDDCC_BBAA);
    wr(16'd1, 32'h0000_00EE);
    bus_idle();
    exp_byte(8'hAA, 1'b0); exp_byte(8'hBB, 1'b0); exp_byte(8'hCC, 1'b0);
    exp_byte(8'hDD, 1'b0); exp_byte(8'hEE, 1'b1);
    tx_mode = 1;
    wr(16'd2, 32'd5);
    bus_idle();
    wait_done(2, "partial_done");
    tx_mode = 0;
    rd(16'd0, 32'h0004_0000);
    bus_idle();

    // Overflow, error clear, zero length.
    for (int i = 0; i < 17; i++) wr(16'd1, word(i));
    rd(16'd0, 32'h0102_0010);
    wr(16'd0, 32'h0100_0000);
    rd(16'd0, 32'h0002_0010);
    wr(16'd2, 32'd0);
    rd(16'd0, 32'h0102_0010);
    wr(16'd0, 32'h0100_0000);
    rd(16'd0, 32'h0002_0010);
    bus_idle();
    repeat (3) @(posedge clk_i);
    #1;
    check("no_tx_len0", {31'd0, tx_valid_o}, 32'd0);

    // 64-byte frame with prefetch pushes and a rejected start while busy.
    for (int b = 0; b < 64; b++) exp_byte(8'(b), (b == 63));
    wr(16'd2, 32'd64);
    repeat (20) bus_idle();
    wr(16'd1, 32'h0403_0201);
    wr(16'd1, 32'h0807_0605);
    wr(16'd2, 32'd8);
    bus_idle();
    wait_done(3, "long_done");
    rd(16'd0, 32'h0100_0002);
    bus_idle();

    // Length needing more words than buffered.
    wr(16'd0, 32'h0100_0000);
    wr(16'd2, 32'd9);
    rd(16'd0, 32'h0100_0002);
    bus_idle();
    repeat (3) @(posedge clk_i);
    #1;
    check("no_tx_len9", {31'd0, tx_valid_o}, 32'd0);
    wr(16'd0, 32'h0100_0000);
    bus_idle();

    // Reset after three bytes of the prefetched frame.
    exp_byte(8'h01, 1'b0); exp_byte(8'h02, 1'b0); exp_byte(8'h03, 1'b0);
    base = tx_cnt;
    wr(16'd2, 32'd8);
    bus_idle();
    n = 0;
    while (tx_cnt < base + 3 && n < 100) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    check("three_bytes_sent", tx_cnt - base, 32'd3);
    @(posedge clk_i);
    #1;
    arst_n_i = 1'b0;
    #1;
    check("reset_mid_frame", {29'd0, tx_valid_o, tx_last_o, busy_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    arst_n_i = 1'b1;
    rd(16'd0, 32'h0004_0000);
    bus_idle();
    repeat (3) @(posedge clk_i);
    #1;
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("tx_q_drained", tx_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_eth_tx_frame_buf.md
Name: iob_eth_tx_frame_buf

Overview:
- CPU-side TX frame buffer that sits between the native-bus register interface and the Ethernet MAC transmit path.
- The CPU pushes 32-bit frame words over the native bus, then writes the frame length to start transmission.
- The block serialises the buffered words into a byte stream (valid/ready/last) consumed by the MAC TX stage.
- Status is readable over the same bus.

Parameters:
- ADDR_W, 16, native-bus address width
- DATA_W, 32, native-bus data width; only 32 is supported
- FIFO_AW, 4, log2 of word FIFO depth (default 16 words)
- LEN_W, 11, frame length field width in bytes (max 2047)

Ports:
- clk_i  in  1  system clock
- arst_n_i  in  1  asynchronous reset, active-low
- valid  in  1  bus request, one cycle per transaction
- address  in  ADDR_W  register address
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  write strobes; nonzero = write, zero = read
- rdata  out  DATA_W  read data, valid while ready=1
- ready  out  1  transaction complete pulse
- tx_data_o  out  8  frame byte to MAC
- tx_valid_o  out  1  tx_data_o valid
- tx_last_o  out  1  final byte of frame
- tx_ready_i  in  1  MAC accepts byte
- busy_o  out  1  frame in transmission
- done_o  out  1  one-cycle pulse after last byte accepted

Behaviour:
- Reset (arst_n_i=0, asynchronous):
  - rdata, ready, tx_data_o, tx_valid_o, tx_last_o, busy_o, done_o = 0.
  - FIFO empty, err=0, FSM=IDLE.
  - Reset mid-frame aborts the frame with no tx_last_o.
- Bus handshake:
  - valid sampled at cycle N; ready=1 for exactly cycle N+1, 0 otherwise.
  - rdata is registered and valid in cycle N+1; it reads 0 for writes.
  - Back-to-back requests are allowed: valid at N and N+1 gives ready at N+1 and N+2.
- Register map (word addresses):
  - 0 STATUS (R):
    - [FIFO_AW:0] = FIFO level in words
    - [16] = busy
    - [17] = full
    - [18] = empty
    - [24] = err (sticky)
  - 0 STATUS (W): wdata[24]=1 clears err.
  - 1 WRITE_FIFO (W): pushes wdata. If the FIFO is full, the write is dropped and err is set. Reads return 0.
  - 2 TX_START (W): len = wdata[LEN_W-1:0]. Accepted only if all three hold: FSM is IDLE, len != 0, and ceil(len/4) <= level. Otherwise the write is ignored and err is set.
  - Any other address: writes ignored, reads return 0, ready still pulses.
- FSM states:
  - IDLE: waits for an accepted TX_START.
  - LOAD: pops one FIFO word into a 32-bit shift register and loads the byte-in-word index to 0.
  - SEND: drives tx_valid_o=1.
  - DONE: pulses done_o for one cycle, then returns to IDLE.
- FSM transitions:
  - IDLE -> LOAD on accepted TX_START at bus cycle N. busy_o=1 from N+1.
  - LOAD -> SEND in one cycle. First tx_valid_o=1 at cycle N+2.
  - SEND, on each handshake (tx_valid_o & tx_ready_i): decrement the byte counter.
    - If remaining bytes = 0: tx_last_o was 1 for this byte; go to DONE.
    - Else if byte index = 3: go to LOAD (one-bubble cycle between words is permitted).
    - Else: shift to the next byte.
  - DONE: busy_o=0 from the same cycle.
- Byte order: little-endian; byte 0 of a word = bits [7:0].
- Partial words: the unused bytes of the final word are discarded, and the word is still popped.
- Stream rules: tx_data_o and tx_last_o are held stable while tx_valid_o=1 and tx_ready_i=0. tx_last_o is asserted only together with tx_valid_o.
- FIFO wrap-around: read and write pointers are FIFO_AW+1 bits. Full is when the MSBs differ and the lower bits are equal.
- Simultaneous events:
  - A push and a LOAD pop in the same cycle are both performed; the level is unchanged.
  - Pushes during busy are allowed (prefetch of the next frame).
  - TX_START during busy sets err.
- Length counter: LEN_W bits; never underflows, since the frame ends at 0.

Test Plan:
- Reset: release arst_n_i, read STATUS -> rdata=0x00040000 (empty=1, level 0), ready exactly one cycle after valid, all tx outputs 0.
- Aligned frame: push 0x44332211, 0x88776655; TX_START len=8 with tx_ready_i=1 -> bytes 11,22,...,88 in order, tx_last_o on 0x88, done_o pulse, STATUS level 0, busy 0.
- Partial frame plus backpressure: push 0xDDCCBBAA, 0x000000EE; len=5; toggle tx_ready_i every other cycle -> AA,BB,CC,DD,EE with held data during stalls, tx_last_o on EE, FIFO empty afterwards.
- Error paths:
  - Push 17 words with FIFO_AW=4 -> level 16, full=1, err=1.
  - Write 0x01000000 to STATUS -> err=0.
  - TX_START len=0 -> err=1, no tx_valid_o.
  - len=9 with 2 words buffered -> err=1, no tx_valid_o.
- Concurrency: during a 64-byte frame, push the next frame's words and issue TX_START -> err=1, current frame completes intact, prefetched words remain (level correct).
- Reset mid-frame: assert arst_n_i after 3 bytes sent -> tx_valid_o=0 immediately, no tx_last_o, STATUS empty after release.
